// File: rtl/poly_rq_to_s3_pkg.sv
// Shared constants, ternary encoding and FSM states for the Rq -> S3 reducer.
// Combinational helpers only; no latency, no flow control.
package poly_rq_to_s3_pkg;
   localparam int NTRU_N     = 701;
   localparam int Q_BITS     = 13;
   localparam int Q_HALF_BIT = Q_BITS - 1;
   localparam int OUT_BEATS  = (NTRU_N + 1) / 2;
   localparam int IN_CNT_W   = $clog2(NTRU_N);
   localparam int OUT_CNT_W  = $clog2(OUT_BEATS);

   typedef logic [1:0] ter_t;
   localparam ter_t TER_ZERO = 2'b00;
   localparam ter_t TER_ONE  = 2'b01;
   localparam ter_t TER_TWO  = 2'b10;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_LOAD,
      ST_DRAIN
   } state_t;

   // (a - b) mod 3 on the 0/1/2 encoding; inputs never hold 2'b11.
   function automatic ter_t sub3(input ter_t a, input ter_t b);
      logic [2:0] s;
      s = {1'b0, a} + 3'd3 - {1'b0, b};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction
endpackage

// File: rtl/poly_rq_to_s3_if.sv
// Serial Rq coefficient input and two-coefficient ternary output, both valid/ready.
// Signal bundle only; no latency, no flow control of its own.
interface poly_rq_to_s3_if;
   import poly_rq_to_s3_pkg::*;

   logic              in_valid;
   logic [Q_BITS-1:0] in_coef;
   logic              in_ready;
   logic              out_valid;
   logic [4:1]        out_m;
   logic              out_ready;
   logic              out_last;

   modport slave (
      input  in_valid, in_coef, out_ready,
      output in_ready, out_valid, out_m, out_last
   );

   modport master (
      output in_valid, in_coef, out_ready,
      input  in_ready, out_valid, out_m, out_last
   );
endinterface

// File: rtl/poly_rq_to_s3_coef_to_ter.sv
// Centred 13-bit Rq coefficient to S3 ternary digit; purely combinational.
// No latency, no flow control.
module rq_coef_to_ter
   import poly_rq_to_s3_pkg::*;
(
   input  logic [Q_BITS-1:0] coef,
   output ter_t              ter
);
   ter_t t;

   // Upper half is a - q, and -q = -8192 = 1 (mod 3), so add one.
   always_comb begin
      t   = ter_t'(coef % Q_BITS'(3));
      ter = t;
      if (coef[Q_HALF_BIT]) ter = (t == TER_TWO) ? TER_ZERO : ter_t'(t + 2'd1);
   end
endmodule

// File: rtl/poly_rq_to_s3.sv
// Loads 701 Rq coefficients, emits them reduced to S3 mod Phi_n two per beat.
// First beat the cycle after coefficient 700; out_m/out_last held under stall, input closed while draining.
module poly_rq_to_s3
   import poly_rq_to_s3_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   poly_rq_to_s3_if.slave bus
);
   state_t                state_q, state_d;
   logic [2*NTRU_N-1:0]   shift_q;
   logic [IN_CNT_W-1:0]   in_cnt_q;
   logic [OUT_CNT_W-1:0]  out_cnt_q;
   ter_t                  top_c_q;
   ter_t                  coef_ter;
   logic                  in_fire, out_fire, in_end, out_end;
   logic                  in_ready_d, out_valid_d, out_last_d;
   logic [4:1]            out_m_d;

   rq_coef_to_ter u_conv (
      .coef (bus.in_coef),
      .ter  (coef_ter)
   );

   assign in_fire  = (state_q == ST_LOAD)  & bus.in_valid;
   assign out_fire = (state_q == ST_DRAIN) & bus.out_ready;
   assign in_end   = (in_cnt_q == IN_CNT_W'(NTRU_N - 1));
   assign out_end  = (out_cnt_q == OUT_CNT_W'(OUT_BEATS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_INIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_m_d     = 4'b0000;
      case (state_q)
         ST_INIT: state_d = ST_LOAD;
         ST_LOAD: begin
            in_ready_d = 1'b1;
            if (in_fire && in_end) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            out_valid_d  = 1'b1;
            out_m_d[2:1] = sub3(shift_q[1:0], top_c_q);
            // Odd count: the last beat carries coefficient 700 alone, upper half padded.
            if (out_end) out_last_d   = 1'b1;
            else         out_m_d[4:3] = sub3(shift_q[3:2], top_c_q);
            if (out_fire && out_end) state_d = ST_LOAD;
         end
         default: state_d = ST_INIT;
      endcase
   end

   assign bus.in_ready  = in_ready_d;
   assign bus.out_valid = out_valid_d;
   assign bus.out_m     = out_m_d;
   assign bus.out_last  = out_last_d;

   // Coefficients enter at the top so coefficient 0 reaches the head after a full frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q   <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         top_c_q   <= TER_ZERO;
      end else begin
         if (in_fire) begin
            shift_q <= {coef_ter, shift_q[2*NTRU_N-1:2]};
            if (in_end) begin
               top_c_q  <= coef_ter;
               in_cnt_q <= '0;
            end else begin
               in_cnt_q <= in_cnt_q + 1'b1;
            end
         end
         if (out_fire) begin
            shift_q <= {4'b0000, shift_q[2*NTRU_N-1:4]};
            if (out_end) out_cnt_q <= '0;
            else         out_cnt_q <= out_cnt_q + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_poly_rq_to_s3.sv
// Directed bench for poly_rq_to_s3 and its coefficient converter.
// Hand-computed frames plus an exhaustive converter sweep against a centred mod-3 model.
module tb_poly_rq_to_s3;
   import poly_rq_to_s3_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [Q_BITS-1:0] coef_mem [NTRU_N];
   logic [4:1]        got_m    [OUT_BEATS];
   logic              got_last [OUT_BEATS];
   int                beats;
   int                unstable;
   int                drain_rdy_err;

   logic [Q_BITS-1:0] cv_coef;
   ter_t              cv_ter;

   poly_rq_to_s3_if bus();

   poly_rq_to_s3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   rq_coef_to_ter u_conv_tb (
      .coef (cv_coef),
      .ter  (cv_ter)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_mem();
      for (int i = 0; i < NTRU_N; i++) coef_mem[i] = '0;
   endtask

   task automatic load_coefs(input int n, input bit gaps);
      int   i;
      int   guard;
      logic acc;
      i = 0;
      guard = 0;
      while (i < n && guard < 20000) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_coef  = coef_mem[i];
         end
         acc = bus.in_valid & bus.in_ready;
         @(posedge clk); #1;
         guard++;
         if (acc) i++;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (i !== n) begin
         errors++;
         $display("FAIL load_accept accepted=%0d required=%0d", i, n);
      end
   endtask

   task automatic collect(input int stall_beat, input int stall_cycles);
      int         guard;
      int         stall_cnt;
      logic       held;
      logic [4:1] held_m;
      logic       held_last;
      logic       rdy;
      guard = 0;
      stall_cnt = 0;
      held = 1'b0;
      held_m = 4'b0000;
      held_last = 1'b0;
      beats = 0;
      unstable = 0;
      drain_rdy_err = 0;
      while (beats < OUT_BEATS && guard < 5000) begin
         rdy = !(beats == stall_beat && stall_cnt < stall_cycles);
         bus.out_ready = rdy;
         if (bus.out_valid) begin
            if (bus.in_ready) drain_rdy_err++;
            if (held && (bus.out_m !== held_m || bus.out_last !== held_last)) unstable++;
            if (!rdy) begin
               stall_cnt++;
               held = 1'b1;
               held_m = bus.out_m;
               held_last = bus.out_last;
            end else begin
               held = 1'b0;
               got_m[beats] = bus.out_m;
               got_last[beats] = bus.out_last;
               beats++;
            end
         end
         @(posedge clk); #1;
         guard++;
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      checks++;
      if (bus.out_m !== 4'b0000) begin errors++; $display("FAIL reset_out_m got=%b want=0000", bus.out_m); end
      checks++;
      if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", bus.out_last); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL init_to_load in_ready got=%b want=1", bus.in_ready); end
   endtask

   task automatic test_zero_frame();
      int bad_m;
      int bad_last;
      clear_mem();
      load_coefs(NTRU_N, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL first_beat_latency out_valid=%b in_ready=%b want 1/0", bus.out_valid, bus.in_ready);
      end
      collect(-1, 0);
      checks++;
      if (beats !== OUT_BEATS) begin errors++; $display("FAIL zero_beats got=%0d want=%0d", beats, OUT_BEATS); end
      bad_m = 0;
      bad_last = 0;
      for (int i = 0; i < beats; i++) begin
         if (got_m[i] !== 4'b0000) bad_m++;
         if (got_last[i] !== (i == OUT_BEATS - 1)) bad_last++;
      end
      checks++;
      if (bad_m !== 0) begin errors++; $display("FAIL zero_data nonzero_beats=%0d want=0", bad_m); end
      checks++;
      if (bad_last !== 0) begin errors++; $display("FAIL zero_last misplaced=%0d want=0", bad_last); end
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL return_to_load in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_small_coefs();
      int bad;
      clear_mem();
      coef_mem[0] = 13'd1;
      coef_mem[1] = 13'd4095;
      load_coefs(NTRU_N, 1'b0);
      collect(-1, 0);
      checks++;
      if (got_m[0] !== 4'b0001) begin errors++; $display("FAIL small_beat0 got=%b want=0001", got_m[0]); end
      bad = 0;
      for (int i = 1; i < OUT_BEATS; i++) if (got_m[i] !== 4'b0000) bad++;
      checks++;
      if (bad !== 0 || beats !== OUT_BEATS) begin
         errors++;
         $display("FAIL small_rest nonzero=%0d beats=%0d want 0/%0d", bad, beats, OUT_BEATS);
      end
   endtask

   task automatic test_negative_coefs();
      int   v;
      int   r;
      ter_t e;
      clear_mem();
      coef_mem[0] = 13'd8191;
      coef_mem[1] = 13'd4096;
      load_coefs(NTRU_N, 1'b0);
      collect(-1, 0);
      checks++;
      if (got_m[0] !== 4'b1010) begin errors++; $display("FAIL neg_beat0 got=%b want=1010", got_m[0]); end
      for (int a = 0; a < 8192; a++) begin
         cv_coef = Q_BITS'(a);
         #1;
         v = (a >= 4096) ? a - 8192 : a;
         r = v % 3;
         if (r < 0) r += 3;
         e = ter_t'(r);
         checks++;
         if (cv_ter !== e) begin errors++; $display("FAIL conv a=%0d got=%b want=%b", a, cv_ter, e); end
      end
   endtask

   task automatic test_phi_reduction();
      int bad;
      clear_mem();
      coef_mem[NTRU_N-1] = 13'd1;
      load_coefs(NTRU_N, 1'b0);
      collect(-1, 0);
      bad = 0;
      for (int i = 0; i < OUT_BEATS - 1; i++) if (got_m[i] !== 4'b1010) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL phi_body wrong_beats=%0d want=0", bad); end
      checks++;
      if (got_m[OUT_BEATS-1] !== 4'b0000 || got_last[OUT_BEATS-1] !== 1'b1) begin
         errors++;
         $display("FAIL phi_last_beat m=%b last=%b want 0000/1", got_m[OUT_BEATS-1], got_last[OUT_BEATS-1]);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      clear_mem();
      coef_mem[6] = 13'd1;
      coef_mem[7] = 13'd8191;
      coef_mem[8] = 13'd4096;
      load_coefs(NTRU_N, 1'b1);
      collect(3, 5);
      checks++;
      if (unstable !== 0) begin errors++; $display("FAIL stall_stable changes=%0d want=0", unstable); end
      checks++;
      if (beats !== OUT_BEATS) begin errors++; $display("FAIL stall_beats got=%0d want=%0d", beats, OUT_BEATS); end
      checks++;
      if (drain_rdy_err !== 0) begin errors++; $display("FAIL drain_in_ready high_cycles=%0d want=0", drain_rdy_err); end
      checks++;
      if (got_m[3] !== 4'b1001) begin errors++; $display("FAIL stall_beat3 got=%b want=1001", got_m[3]); end
      checks++;
      if (got_m[4] !== 4'b0010) begin errors++; $display("FAIL stall_beat4 got=%b want=0010", got_m[4]); end
      bad = 0;
      for (int i = 0; i < OUT_BEATS; i++) if (i != 3 && i != 4 && got_m[i] !== 4'b0000) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL stall_rest nonzero=%0d want=0", bad); end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_extra out_valid=%b want=0", bus.out_valid); end
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      for (int i = 0; i < NTRU_N; i++) coef_mem[i] = Q_BITS'((i * 37 + 5) % 8192);
      load_coefs(300, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready got=%b want=0", bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b want=0", bus.out_valid); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_mem();
      load_coefs(NTRU_N, 1'b0);
      collect(-1, 0);
      bad = 0;
      for (int i = 0; i < OUT_BEATS; i++) if (got_m[i] !== 4'b0000) bad++;
      checks++;
      if (bad !== 0 || beats !== OUT_BEATS) begin
         errors++;
         $display("FAIL post_reset_frame nonzero=%0d beats=%0d want 0/%0d", bad, beats, OUT_BEATS);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_coef = '0;
      bus.out_ready = 1'b0;
      cv_coef = '0;
      #2;
      test_reset();
      test_zero_frame();
      test_small_coefs();
      test_negative_coefs();
      test_phi_reduction();
      test_backpressure();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
